// File: rtl/rr_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter
//
// Round-robin arbiter that owns the select lines of a shared 4:1, WIDTH-bit
// multiplexer. A requester keeps its grant for as long as it keeps requesting.
// When someone else is also waiting, it keeps the grant for at most MAX_HOLD
// consecutive cycles. The arbiter moves from one owner straight to the next,
// with no idle cycle in between.
//
// Parameters:
//   WIDTH      data lane width in bits (>= 1)
//   MAX_HOLD   max consecutive grant cycles while another requester waits (>= 1)
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous active-high reset
//   req_i       level-sensitive request, one bit per requester
//   data_in_i   four packed lanes, lane i = data_in_i[i*WIDTH +: WIDTH]
//   gnt_o       registered one-hot grant, zero when idle
//   sel_o       registered binary index of the current grant (mux select)
//   valid_o     registered, high exactly when gnt_o is non-zero
//   data_out_o  selected lane while valid, otherwise all zeros
// ---------------------------------------------------------------------------
module rr_mux4_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req_i,
    input  logic [4*WIDTH-1:0]   data_in_i,
    output logic [3:0]           gnt_o,
    output logic [1:0]           sel_o,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     data_out_o
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          valid_q, valid_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ownerReq;
    logic [3:0]    othersMask;
    logic          othersReq;
    logic [3:0]    arbMask;
    logic          pickFound;
    logic [1:0]    pickIdx;
    logic          doArb;

    // Returns {found, index} for the first set bit of mask, searching start,
    // start+1, ... modulo 4. The loop runs from the farthest offset down to the
    // nearest one, so the nearest set bit is the last one written and wins.
    function automatic logic [2:0] pickFirst(input logic [3:0] mask,
                                             input logic [1:0] start);
        logic [1:0] idx;
        pickFirst = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) begin
                pickFirst = {1'b1, idx};
            end
        end
    endfunction

    // Next-state logic. The owner is excluded from every arbitration made in
    // GRANT. On a forced release this is what makes the new owner differ from
    // the old one. On a voluntary release the owner's request is already low,
    // so the mask changes nothing.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        doArb      = 1'b0;

        ownerReq   = req_i[sel_q];
        othersMask = req_i & ~(4'b0001 << sel_q);
        othersReq  = |othersMask;
        arbMask    = (state_q == IDLE) ? req_i : othersMask;
        {pickFound, pickIdx} = pickFirst(arbMask, ptr_q);

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    doArb = 1'b1;
                end
            end
            GRANT: begin
                if (!ownerReq || (othersReq && (cnt_q == HOLD_MAX))) begin
                    doArb = 1'b1;
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (doArb) begin
            if (pickFound) begin
                state_d = GRANT;
                gnt_d   = 4'b0001 << pickIdx;
                sel_d   = pickIdx;
                valid_d = 1'b1;
                cnt_d   = CW'(1);
                ptr_d   = pickIdx + 2'd1;
            end else begin
                // Nobody else wants the mux. Go idle and leave sel where it is.
                state_d = IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        end
    end

    // State and output registers. Reset clears everything at once, so the
    // outputs return to zero without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shared datapath mux. The lane is gated by valid, so the stale sel value
    // kept while idle never reaches the output.
    always_comb begin
        data_out_o = '0;
        if (valid_q) begin
            data_out_o = data_in_i[sel_q*WIDTH +: WIDTH];
        end
    end

    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux4_arbiter
//
// Directed bench for rr_mux4_arbiter with WIDTH=8 and MAX_HOLD=4.
//
// At each falling edge the stimulus process drives req and pushes the
// hand-computed grant expected after the next rising edge. A monitor pops one
// entry 1 ns after each rising edge and compares gnt, sel, valid and data_out.
// Reset behaviour and the combinational data path are checked directly.
// ---------------------------------------------------------------------------
module tb_rr_mux4_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic [3:0]       gnt;
        logic [1:0]       sel;
        logic             valid;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [3:0]         req;
    logic [WIDTH-1:0]   lane [4];
    logic [4*WIDTH-1:0] dataIn;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic               valid;
    logic [WIDTH-1:0]   dataOut;

    exp_t               expQ[$];
    logic [1:0]         lastSel;
    int                 errors;
    int                 checks;

    assign dataIn = {lane[3], lane[2], lane[1], lane[0]};

    rr_mux4_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .data_in_i  (dataIn),
        .gnt_o      (gnt),
        .sel_o      (sel),
        .valid_o    (valid),
        .data_out_o (dataOut)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: bumps the counters and reports a mismatch
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of requests and queues the expected post-edge outputs.
    // sel keeps its previous value while the grant is zero.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] expGnt);
        exp_t e;
        @(negedge clk);
        req = r;
        case (expGnt)
            4'b0001: lastSel = 2'd0;
            4'b0010: lastSel = 2'd1;
            4'b0100: lastSel = 2'd2;
            4'b1000: lastSel = 2'd3;
            default: ;
        endcase
        e.gnt   = expGnt;
        e.sel   = lastSel;
        e.valid = (expGnt != 4'b0000);
        e.data  = e.valid ? lane[lastSel] : '0;
        expQ.push_back(e);
    endtask

    task automatic applyRepeat(input logic [3:0] r, input logic [3:0] expGnt, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(r, expGnt);
        end
    endtask

    // Asserts reset between clock edges and checks that the outputs clear
    // without a clock edge
    task automatic asyncReset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        req = 4'b0000;
        #1;
        checkOutput("reset gnt", 32'(gnt), 32'h0);
        checkOutput("reset sel", 32'(sel), 32'h0);
        checkOutput("reset valid", 32'(valid), 32'h0);
        checkOutput("reset data_out", 32'(dataOut), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        lastSel = 2'd0;
    endtask

    // Monitor: compares one queued expectation per rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("gnt", 32'(gnt), 32'(e.gnt));
            checkOutput("sel", 32'(sel), 32'(e.sel));
            checkOutput("valid", 32'(valid), 32'(e.valid));
            checkOutput("data_out", 32'(dataOut), 32'(e.data));
        end
    end

    initial begin
        errors  = 0;
        checks  = 0;
        lastSel = 2'd0;
        rst     = 1'b1;
        req     = 4'b0000;
        lane[0] = 8'h11;
        lane[1] = 8'h22;
        lane[2] = 8'hA5;
        lane[3] = 8'h44;

        #7;
        checkOutput("initial reset gnt", 32'(gnt), 32'h0);
        checkOutput("initial reset valid", 32'(valid), 32'h0);
        checkOutput("initial reset data_out", 32'(dataOut), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester: the grant holds past MAX_HOLD because nobody else waits
        applyRepeat(4'b0100, 4'b0100, 10);

        // Reset in the middle of the grant, then full contention from requester 0
        asyncReset();
        applyRepeat(4'b1111, 4'b0001, 4);
        applyRepeat(4'b1111, 4'b0010, 4);
        applyRepeat(4'b1111, 4'b0100, 4);
        applyRepeat(4'b1111, 4'b1000, 4);
        applyStimulus(4'b1111, 4'b0001);
        applyStimulus(4'b0000, 4'b0000);

        // Simultaneous first requests out of reset, then both owners drop
        asyncReset();
        applyRepeat(4'b1001, 4'b0001, 2);
        applyRepeat(4'b1000, 4'b1000, 2);
        applyStimulus(4'b0000, 4'b0000);

        // Early release: owner 1 drops while requester 3 is waiting
        applyStimulus(4'b0010, 4'b0010);
        applyStimulus(4'b1010, 4'b0010);
        applyStimulus(4'b1000, 4'b1000);

        // Pointer wrap: owner 3 is forced off with req=1011, and the grant goes to 0, not 1
        applyRepeat(4'b1011, 4'b1000, 3);
        applyStimulus(4'b1011, 4'b0001);

        // data_out follows a lane change without waiting for a clock edge
        @(posedge clk);
        #3;
        lane[0] = 8'h5A;
        #1;
        checkOutput("data_out comb follow", 32'(dataOut), 32'h5A);
        applyStimulus(4'b0000, 4'b0000);

        // Wait a bounded number of cycles for the monitor to drain the queue
        for (int i = 0; i < 5 && expQ.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("queue drained", 32'(expQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
